regfile_selftest: RTL and testbench

//  Parametrised board-level front end for exercising a register file (RV32I-style: x0 reads zero, sync write, comb read).

---
 rtl/regfile_selftest.sv | 195 +++++++++++++++++++
 tb/tb_regfile_selftest.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_selftest.sv
// Board front end for a register file: byte-serial manual loading from switches
// plus an autonomous two-pass write/readback march with error capture.
module regfile_selftest #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            start,
    input  logic            clki,
    input  logic [2:0]      seld,
    input  logic [7:0]      src,
    input  logic [2:0]      selm,
    output logic            rf_we3,
    output logic [AW-1:0]   rf_a1,
    output logic [AW-1:0]   rf_a2,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [31:0]     disp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_cnt,
    output logic [AW-1:0]   fail_addr
);

    localparam int NB = XLEN / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

    function automatic logic [XLEN-1:0] pat(input logic [AW-1:0] i);
        return {NB{(8'(i) ^ 8'hA5)}};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic              start_p0, start_p1, start_p2;
    logic              clki_p0, clki_p1, clki_p2;
    logic              start_rise, clki_rise, go_st, man_go, man_we;
    logic              have_fail, rd_err;
    logic [XLEN-1:0]   wd, exp_val, exp_fail;
    logic [AW-1:0]     a1, a2, a3;
    logic [BW-1:0]     byte_ptr;
    logic [BW+2:0]     bofs;

    // Stage p0..p2: two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {start_p0, start_p1, start_p2} <= 3'b000;
            {clki_p0, clki_p1, clki_p2}    <= 3'b000;
        end else begin
            {start_p0, start_p1, start_p2} <= {start, start_p0, start_p1};
            {clki_p0, clki_p1, clki_p2}    <= {clki, clki_p0, clki_p1};
        end
    end

    assign start_rise = start_p1 & ~start_p2;
    assign clki_rise  = clki_p1 & ~clki_p2;
    assign go_st      = mode && start_rise && (state == IDLE || state == DONE);
    assign man_go     = clki_rise && !mode && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Dropping mode aborts from any state; a start while busy falls through unchanged
    always_comb begin
        state_nxt = state;
        if (!mode) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start_rise) state_nxt = W0;
                W0:         if (idx == LAST) state_nxt = R0;
                R0:         if (idx == LAST) state_nxt = W1;
                W1:         if (idx == LAST) state_nxt = R1;
                R1:         if (idx == LAST) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state == W0) || (state == R0) || (state == W1) || (state == R1);
        done   = (state == DONE);
        pass   = done && (err_cnt == 8'd0);
        rf_we3 = man_we;
        rf_a1  = a1;
        rf_a2  = a2;
        rf_a3  = a3;
        rf_wd3 = wd;
        case (state)
            W0: begin rf_we3 = 1'b1; rf_a3 = idx; rf_wd3 = pat(idx);  end
            W1: begin rf_we3 = 1'b1; rf_a3 = idx; rf_wd3 = ~pat(idx); end
            R0, R1: begin rf_a1 = idx; rf_a2 = idx; end
            default: ;
        endcase
    end

    // Writes skip x0, so write passes start at 1 and read passes at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (go_st) begin
            idx <= AW'(1);
        end else begin
            case (state)
                W0, W1:  idx <= (idx == LAST) ? '0 : idx + 1'b1;
                R0:      idx <= (idx == LAST) ? AW'(1) : idx + 1'b1;
                R1:      idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        exp_val = '0;
        if (idx != '0) exp_val = (state == R1) ? ~pat(idx) : pat(idx);
        exp_fail = (fail_addr == '0) ? '0 : pat(fail_addr);
        rd_err   = ((state == R0) || (state == R1)) &&
                   ((rf_rd1 != exp_val) || (rf_rd2 != exp_val));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= 8'd0;
            fail_addr <= '0;
            have_fail <= 1'b0;
        end else if (go_st) begin
            err_cnt   <= 8'd0;
            fail_addr <= '0;
            have_fail <= 1'b0;
        end else if (rd_err) begin
            err_cnt <= sat_inc(err_cnt);
            if (!have_fail) begin
                fail_addr <= idx;
                have_fail <= 1'b1;
            end
        end
    end

    assign bofs = {byte_ptr, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd       <= '0;
            a1       <= '0;
            a2       <= '0;
            a3       <= '0;
            byte_ptr <= '0;
            man_we   <= 1'b0;
        end else begin
            man_we <= 1'b0;
            if (man_go) begin
                case (seld)
                    3'd0: begin
                        wd[bofs +: 8] <= src;
                        byte_ptr      <= (byte_ptr == BW'(NB - 1)) ? '0 : byte_ptr + 1'b1;
                    end
                    3'd1: begin wd <= '0; byte_ptr <= '0; end
                    3'd2: a1 <= src[AW-1:0];
                    3'd3: a2 <= src[AW-1:0];
                    3'd4: a3 <= src[AW-1:0];
                    3'd5: man_we <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (selm)
            3'd0:    disp = 32'(wd);
            3'd1:    disp = 32'(rf_rd1);
            3'd2:    disp = 32'(rf_rd2);
            3'd3:    disp = {8'h00, 8'(a1), 8'(a2), 8'(a3)};
            3'd4:    disp = {err_cnt, 16'h0000, 8'(fail_addr)};
            3'd5:    disp = 32'(exp_fail);
            3'd6:    disp = {29'd0, busy, done, pass};
            default: disp = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_regfile_selftest.sv
// Directed bench for regfile_selftest: manual loading, self-test with fault
// models, abort, asynchronous reset, and error saturation on a 256-entry build.
module tb_regfile_selftest;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NREGS2 = 256;
    localparam int AW2 = 8;

    logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, start = 1'b0, clki = 1'b0;
    logic mode2 = 1'b0, start2 = 1'b0;
    logic [2:0] seld = 3'd0, selm = 3'd0;
    logic [7:0] src = 8'd0;

    logic rf_we3, busy, done, pass;
    logic [AW-1:0] rf_a1, rf_a2, rf_a3, fail_addr;
    logic [XLEN-1:0] rf_wd3, rf_rd1, rf_rd2;
    logic [31:0] disp;
    logic [7:0] err_cnt;

    logic rf_we3_2, busy2, done2, pass2;
    logic [AW2-1:0] rf_a1_2, rf_a2_2, rf_a3_2, fail2;
    logic [XLEN-1:0] rf_wd3_2, rf_rd1_2, rf_rd2_2;
    logic [31:0] disp2;
    logic [7:0] err2;

    regfile_selftest #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .clki(clki),
        .seld(seld), .src(src), .selm(selm), .rf_we3(rf_we3), .rf_a1(rf_a1),
        .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_rd1(rf_rd1),
        .rf_rd2(rf_rd2), .disp(disp), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    regfile_selftest #(.XLEN(XLEN), .NREGS(NREGS2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .start(start2), .clki(clki),
        .seld(seld), .src(src), .selm(selm), .rf_we3(rf_we3_2), .rf_a1(rf_a1_2),
        .rf_a2(rf_a2_2), .rf_a3(rf_a3_2), .rf_wd3(rf_wd3_2), .rf_rd1(rf_rd1_2),
        .rf_rd2(rf_rd2_2), .disp(disp2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_addr(fail2)
    );

    always #5 clk = ~clk;

    // Register file model; fault 1: reg 7 bit 3 stuck-at-1, fault 2: x0 reads all ones
    logic [31:0] mem [0:NREGS-1];
    int fault = 0;
    always @(posedge clk) if (rf_we3 && rf_a3 != '0) mem[rf_a3] <= rf_wd3;
    assign rf_rd1 = (rf_a1 == '0) ? ((fault == 2) ? 32'hFFFF_FFFF : 32'h0)
                  : (mem[rf_a1] | ((fault == 1 && rf_a1 == 5'd7) ? 32'h8 : 32'h0));
    assign rf_rd2 = (rf_a2 == '0) ? ((fault == 2) ? 32'hFFFF_FFFF : 32'h0)
                  : (mem[rf_a2] | ((fault == 1 && rf_a2 == 5'd7) ? 32'h8 : 32'h0));

    // Second register file always returns data that matches neither pass pattern
    assign rf_rd1_2 = {4{rf_a1_2 ^ 8'h3C}};
    assign rf_rd2_2 = {4{rf_a2_2 ^ 8'h3C}};

    int we_cnt = 0, busy_edges = 0, we2_cnt = 0;
    logic [AW-1:0] we_a3 = '0;
    logic [31:0] we_wd = '0, we2_last = '0;
    always @(posedge clk) begin
        if (rf_we3) begin
            we_cnt <= we_cnt + 1;
            we_a3  <= rf_a3;
            we_wd  <= rf_wd3;
        end
        if (busy) busy_edges <= busy_edges + 1;
        if (rf_we3_2 && rf_a3_2 != '0) begin
            we2_cnt  <= we2_cnt + 1;
            we2_last <= rf_wd3_2;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [2:0] s, input logic [7:0] d);
        seld = s; src = d; clki = 1'b1;
        tick(4);
        clki = 1'b0;
        tick(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(4);
        start = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string tag, input int lim);
        for (int i = 0; i < lim && !done; i++) tick(1);
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, bb, w2b;

        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_fail", 32'(fail_addr), 32'd0);
        check("rst_we", 32'(rf_we3), 32'd0);
        check("rst_wd3", rf_wd3, 32'd0);
        check("rst_disp", disp, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Manual load and commit
        wb = we_cnt;
        strobe(3'd1, 8'h00);
        strobe(3'd0, 8'h78);
        strobe(3'd0, 8'h56);
        strobe(3'd0, 8'h34);
        strobe(3'd0, 8'h12);
        strobe(3'd4, 8'h05);
        check("wd_bytes", disp, 32'h1234_5678);
        strobe(3'd5, 8'h00);
        check("commit_once", 32'(we_cnt - wb), 32'd1);
        check("commit_a3", 32'(we_a3), 32'd5);
        check("commit_wd", we_wd, 32'h1234_5678);
        check("commit_end", 32'(rf_we3), 32'd0);
        strobe(3'd2, 8'h05);
        selm = 3'd1; tick(1);
        check("rd1_readback", disp, 32'h1234_5678);
        selm = 3'd3; tick(1);
        check("addr_disp", disp, 32'h0005_0005);
        strobe(3'd0, 8'hAA);
        selm = 3'd0; tick(1);
        check("byte_wrap", disp, 32'h1234_56AA);

        // Ideal self-test, start latency, restart ignored while busy
        mode = 1'b1;
        tick(2);
        wb = we_cnt;
        start = 1'b1;
        tick(2);
        check("start_lat2", 32'(busy), 32'd0);
        tick(1);
        check("start_lat3", 32'(busy), 32'd1);
        bb = busy_edges;
        start = 1'b0;
        tick(10);
        start = 1'b1;
        tick(5);
        start = 1'b0;
        wait_done("t2_done", 300);
        check("busy_len", 32'(busy_edges - bb), 32'd126);
        check("t2_writes", 32'(we_cnt - wb), 32'd62);
        check("t2_pass", 32'(pass), 32'd1);
        check("t2_err", 32'(err_cnt), 32'd0);
        selm = 3'd6; tick(1);
        check("t2_status", disp, 32'd3);

        // Manual strobe ignored in self-test mode
        strobe(3'd1, 8'h00);
        strobe(3'd2, 8'h1F);
        selm = 3'd0; tick(1);
        check("clki_ign_wd", disp, 32'h1234_56AA);
        selm = 3'd3; tick(1);
        check("clki_ign_a", disp, 32'h0005_0005);

        // Stuck bit on reg 7
        fault = 1;
        pulse_start();
        wait_done("t3_done", 300);
        check("t3_err", 32'(err_cnt), 32'd1);
        check("t3_fail", 32'(fail_addr), 32'd7);
        check("t3_pass", 32'(pass), 32'd0);
        selm = 3'd5; tick(1);
        check("t3_exp", disp, 32'hA2A2_A2A2);

        // x0 reads non-zero
        fault = 2;
        pulse_start();
        wait_done("t4_done", 300);
        check("t4_err", 32'(err_cnt), 32'd2);
        check("t4_fail", 32'(fail_addr), 32'd0);
        check("t4_pass", 32'(pass), 32'd0);
        selm = 3'd4; tick(1);
        check("t4_disp", disp, 32'h0200_0000);

        // Abort during W1
        pulse_start();
        tick(70);
        check("in_w1", 32'(rf_we3), 32'd1);
        mode = 1'b0;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(rf_we3), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err_cnt), 32'd1);
        selm = 3'd0; tick(1);
        check("abort_wd", disp, 32'h1234_56AA);

        // Asynchronous reset during R0
        mode = 1'b1;
        tick(1);
        pulse_start();
        tick(40);
        check("r0_err_pre", 32'(err_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err_cnt), 32'd0);
        check("arst_we", 32'(rf_we3), 32'd0);
        check("arst_a1", 32'(rf_a1), 32'd0);
        check("arst_wd", disp, 32'd0);
        rst_n = 1'b1;
        mode = 1'b0;
        tick(2);

        // 256-entry build with every read wrong
        mode2 = 1'b1;
        tick(1);
        w2b = we2_cnt;
        start2 = 1'b1;
        tick(4);
        start2 = 1'b0;
        for (int i = 0; i < 1200 && !done2; i++) tick(1);
        check("t6_done", 32'(done2), 32'd1);
        check("t6_err_sat", 32'(err2), 32'd255);
        check("t6_fail", 32'(fail2), 32'd0);
        check("t6_pass", 32'(pass2), 32'd0);
        check("t6_writes", 32'(we2_cnt - w2b), 32'd510);
        check("t6_last_wd", we2_last, 32'hA5A5_A5A5);
        selm = 3'd4; tick(1);
        check("t6_disp", disp2, 32'hFF00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
